// File: rtl/eth_pkg.sv
// Shared Ethernet/IPv4/UDP receive definitions: protocol constants, header
// byte offsets (counted from the first byte after the SFD), receive FSM
// states and a ones-complement adder helper.
package eth_pkg;

   localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
   localparam logic [7:0]  IP_PROTO_UDP   = 8'h11;
   localparam logic [7:0]  IPV4_VER_IHL   = 8'h45;
   localparam logic [7:0]  SFD            = 8'hD5;
   localparam logic [7:0]  PREAMBLE_BYTE  = 8'h55;

   localparam logic [5:0] MAC_DST_OFS   = 6'd0;
   localparam logic [5:0] MAC_SRC_OFS   = 6'd6;
   localparam logic [5:0] ETHERTYPE_OFS = 6'd12;
   localparam logic [5:0] IP_VER_OFS    = 6'd14;
   localparam logic [5:0] IP_PROTO_OFS  = 6'd23;
   localparam logic [5:0] IP_CSUM_OFS   = 6'd24;
   localparam logic [5:0] IP_SRC_OFS    = 6'd26;
   localparam logic [5:0] IP_DST_OFS    = 6'd30;
   localparam logic [5:0] UDP_SRC_OFS   = 6'd34;
   localparam logic [5:0] UDP_DST_OFS   = 6'd36;
   localparam logic [5:0] UDP_LEN_OFS   = 6'd38;
   localparam logic [5:0] UDP_CSUM_OFS  = 6'd40;
   localparam logic [5:0] PAYLOAD_OFS   = 6'd42;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      PREAMBLE = 3'd1,
      HDR      = 3'd2,
      PAYLOAD  = 3'd3,
      DRAIN    = 3'd4,
      DROP     = 3'd5
   } udp_rx_state_t;

   // 16-bit ones-complement addition with end-around carry
   function automatic logic [15:0] oc_add(input logic [15:0] a, input logic [15:0] b);
      logic [16:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[15:0] + {15'd0, s[16]};
   endfunction

endpackage

// File: rtl/ip_csum_acc.sv
// Ones-complement accumulator fed one byte per enable; bytes are paired
// high-then-low into 16-bit words. 'sum' already includes the word being
// completed by the current byte so the caller can test it in the same cycle.
module ip_csum_acc
   import eth_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clr,
   input  logic        en,
   input  logic [7:0]  data,
   output logic [15:0] sum
);

   logic [15:0] acc;
   logic [7:0]  hi;
   logic        phase;

   // accumulate completed byte pairs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc   <= '0;
         hi    <= '0;
         phase <= 1'b0;
      end else if (clr) begin
         acc   <= '0;
         hi    <= '0;
         phase <= 1'b0;
      end else if (en) begin
         if (!phase) begin
            hi    <= data;
            phase <= 1'b1;
         end else begin
            acc   <= oc_add(acc, {hi, data});
            phase <= 1'b0;
         end
      end
   end

   // look-ahead sum including the pair closing this cycle
   always_comb begin
      sum = acc;
      if (en && phase) sum = oc_add(acc, {hi, data});
   end

endmodule

// File: rtl/udp_recv.sv
// UDP receiver: parses the GMII RX byte stream (preamble, SFD, Ethernet II,
// IPv4, UDP) and forwards the payload of frames addressed to this node and
// listen port as a byte stream with sop/eop, one cycle behind the input.
// Optional: define IP_CSUM_CHECK_EN to verify the IPv4 header checksum.
module udp_recv
   import eth_pkg::*;
#(
   parameter logic [47:0] SELF_MAC    = 48'h0023543C471B,
   parameter logic [31:0] SELF_IP     = 32'h0A000021,
   parameter logic [15:0] LISTEN_PORT = 16'd5000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  i_data,
   input  logic        i_data_vl,
   output logic [7:0]  o_data,
   output logic        o_data_vl,
   output logic        o_sop,
   output logic        o_eop,
   output logic        o_abort,
   output logic [31:0] o_src_ip,
   output logic [15:0] o_src_port,
   output logic [15:0] o_pay_len,
   output logic [15:0] o_ok_cnt,
   output logic [15:0] o_drop_cnt
);

   udp_rx_state_t state;
   logic [5:0]    k;
   logic [39:0]   sr;
   logic [47:0]   cur48;
   logic [15:0]   cur16;
   logic [31:0]   src_ip_sh;
   logic [15:0]   src_port_sh;
   logic [15:0]   pay_len_sh;
   logic [15:0]   pay_cnt;
   logic          vl_d;
   logic          vl_rise;
   logic          hdr_bad;
   logic          csum_bad;

   // header field ending at the current byte, most recent byte in bits [7:0]
   assign cur48   = {sr, i_data};
   assign cur16   = cur48[15:0];
   assign vl_rise = i_data_vl && !vl_d;

`ifdef IP_CSUM_CHECK_EN
   logic [15:0] csum_sum;
   logic        csum_clr;
   logic        csum_en;

   assign csum_clr = (state != HDR);
   assign csum_en  = (state == HDR) && i_data_vl &&
                     (k >= IP_VER_OFS) && (k <= IP_DST_OFS + 6'd3);

   ip_csum_acc u_ip_csum_acc (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (csum_clr),
      .en    (csum_en),
      .data  (i_data),
      .sum   (csum_sum)
   );

   assign csum_bad = (csum_sum != 16'hFFFF);
`else
   assign csum_bad = 1'b0;
`endif

   // per-byte header field checks, evaluated at the byte completing each field
   always_comb begin
      hdr_bad = 1'b0;
      case (k)
         MAC_DST_OFS + 6'd5:   hdr_bad = !((cur48 == SELF_MAC) || (cur48 == '1));
         ETHERTYPE_OFS + 6'd1: hdr_bad = (cur16 != ETHERTYPE_IPV4);
         IP_VER_OFS:           hdr_bad = (i_data != IPV4_VER_IHL);
         IP_PROTO_OFS:         hdr_bad = (i_data != IP_PROTO_UDP);
         IP_DST_OFS + 6'd3:    hdr_bad = (cur48[31:0] != SELF_IP) || csum_bad;
         UDP_DST_OFS + 6'd1:   hdr_bad = (cur16 != LISTEN_PORT);
         UDP_LEN_OFS + 6'd1:   hdr_bad = (cur16 < 16'd8);
         default:              hdr_bad = 1'b0;
      endcase
   end

   // receive FSM, payload output register and frame counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         k           <= '0;
         sr          <= '0;
         src_ip_sh   <= '0;
         src_port_sh <= '0;
         pay_len_sh  <= '0;
         pay_cnt     <= '0;
         // starts high so a frame already in flight at reset release is not
         // mistaken for a new start; the next real rising edge is needed
         vl_d        <= 1'b1;
         o_data      <= '0;
         o_data_vl   <= 1'b0;
         o_sop       <= 1'b0;
         o_eop       <= 1'b0;
         o_abort     <= 1'b0;
         o_src_ip    <= '0;
         o_src_port  <= '0;
         o_pay_len   <= '0;
         o_ok_cnt    <= '0;
         o_drop_cnt  <= '0;
      end else begin
         vl_d      <= i_data_vl;
         o_data_vl <= 1'b0;
         o_sop     <= 1'b0;
         o_eop     <= 1'b0;
         o_abort   <= 1'b0;
         case (state)
            IDLE: begin
               k <= '0;
               if (vl_rise) begin
                  if (i_data == PREAMBLE_BYTE) begin
                     state <= PREAMBLE;
                  end else if (i_data == SFD) begin
                     state <= HDR;
                  end else begin
                     state      <= DROP;
                     o_drop_cnt <= o_drop_cnt + 16'd1;
                  end
               end
            end
            PREAMBLE: begin
               k <= '0;
               if (!i_data_vl) begin
                  state <= IDLE;
               end else if (i_data == SFD) begin
                  state <= HDR;
               end else if (i_data != PREAMBLE_BYTE) begin
                  state      <= DROP;
                  o_drop_cnt <= o_drop_cnt + 16'd1;
               end
            end
            HDR: begin
               if (!i_data_vl) begin
                  state      <= IDLE;
                  o_drop_cnt <= o_drop_cnt + 16'd1;
               end else if (hdr_bad) begin
                  state      <= DROP;
                  o_drop_cnt <= o_drop_cnt + 16'd1;
               end else begin
                  sr <= cur48[39:0];
                  k  <= k + 6'd1;
                  if (k == IP_SRC_OFS + 6'd3)  src_ip_sh   <= cur48[31:0];
                  if (k == UDP_SRC_OFS + 6'd1) src_port_sh <= cur16;
                  if (k == UDP_LEN_OFS + 6'd1) pay_len_sh  <= cur16 - 16'd8;
                  if (k == PAYLOAD_OFS - 6'd1) begin
                     o_src_ip   <= src_ip_sh;
                     o_src_port <= src_port_sh;
                     o_pay_len  <= pay_len_sh;
                     pay_cnt    <= '0;
                     if (pay_len_sh == '0) begin
                        state    <= DRAIN;
                        o_ok_cnt <= o_ok_cnt + 16'd1;
                     end else begin
                        state <= PAYLOAD;
                     end
                  end
               end
            end
            PAYLOAD: begin
               if (!i_data_vl) begin
                  state      <= IDLE;
                  o_abort    <= 1'b1;
                  o_drop_cnt <= o_drop_cnt + 16'd1;
               end else begin
                  o_data    <= i_data;
                  o_data_vl <= 1'b1;
                  o_sop     <= (pay_cnt == '0);
                  pay_cnt   <= pay_cnt + 16'd1;
                  if (pay_cnt + 16'd1 == o_pay_len) begin
                     o_eop    <= 1'b1;
                     o_ok_cnt <= o_ok_cnt + 16'd1;
                     state    <= DRAIN;
                  end
               end
            end
            DRAIN, DROP: begin
               if (!i_data_vl) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
